// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the long-latency write scoreboard: register/word types,
// forwarding payload and scoreboard entry layout.
package fwd_scoreboard_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CREG_W    = 5;
  localparam int unsigned NUM_CREGS = 32;
  localparam int unsigned SB_ID_W   = 3;
  localparam int unsigned SB_CNT_W  = 6;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [CREG_W-1:0] creg_addr_t;

  typedef struct packed {
    logic  enable;
    word_t data;
  } fwd_data_t;

  typedef struct packed {
    logic               busy;
    logic               ready;
    logic [SB_ID_W-1:0] id;
    word_t              data;
  } sb_entry_t;

endpackage

// File: rtl/fwd_scoreboard_query.sv
// One decode-source lookup: returns the held result, or the same-cycle done
// result, for a busy entry; otherwise flags the source as pending.
module sb_query
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned ID_W = SB_ID_W
) (
  input  logic [NUM_CREGS-1:0] busy,
  input  logic [NUM_CREGS-1:0] ready,
  input  logic [ID_W-1:0]      id [NUM_CREGS],
  input  word_t                data [NUM_CREGS],
  input  logic                 done_valid,
  input  creg_addr_t           done_dst,
  input  logic [ID_W-1:0]      done_id,
  input  word_t                done_data,
  input  creg_addr_t           src,
  output fwd_data_t            fwd_c,
  output logic                 pending_c
);

  always_comb begin
    fwd_c     = '0;
    pending_c = 1'b0;
    if (src != '0 && busy[src]) begin
      if (ready[src]) begin
        fwd_c.enable = 1'b1;
        fwd_c.data   = data[src];
      end else if (done_valid && done_dst == src && done_id == id[src]) begin
        // Result arriving this cycle: bypass it ahead of the register write.
        fwd_c.enable = 1'b1;
        fwd_c.data   = done_data;
      end else begin
        pending_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Tracks long-latency register writes from issue to commit and forwards
// completed-but-uncommitted results to two decode-stage source queries.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned ID_W = SB_ID_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  input  creg_addr_t          issue_dst,
  input  logic [ID_W-1:0]     issue_id,
  input  logic                done_valid,
  input  creg_addr_t          done_dst,
  input  logic [ID_W-1:0]     done_id,
  input  word_t               done_data,
  input  logic                commit_valid,
  input  creg_addr_t          commit_dst,
  input  logic [ID_W-1:0]     commit_id,
  input  creg_addr_t          src1,
  input  creg_addr_t          src2,
  output fwd_data_t           fwd1,
  output fwd_data_t           fwd2,
  output logic                stall,
  output logic [SB_CNT_W-1:0] busy_cnt
);

  logic [NUM_CREGS-1:0] busy_q, busy_d;
  logic [NUM_CREGS-1:0] ready_q, ready_d;
  logic [ID_W-1:0]      id_q [NUM_CREGS];
  logic [ID_W-1:0]      id_d [NUM_CREGS];
  word_t                data_q [NUM_CREGS];
  word_t                data_d [NUM_CREGS];
  logic [SB_CNT_W-1:0]  busy_cnt_d;
  logic                 pending1_c, pending2_c;

  // Per-entry update: flush > issue > matching commit > matching done.
  // Entry 0 is never written, so it stays clear from reset onward.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    id_d    = id_q;
    data_d  = data_q;
    for (int unsigned r = 1; r < NUM_CREGS; r++) begin
      if (flush) begin
        busy_d[CREG_W'(r)]  = 1'b0;
        ready_d[CREG_W'(r)] = 1'b0;
        id_d[CREG_W'(r)]    = '0;
        data_d[CREG_W'(r)]  = '0;
      end else if (issue_valid && issue_dst == CREG_W'(r)) begin
        busy_d[CREG_W'(r)]  = 1'b1;
        ready_d[CREG_W'(r)] = 1'b0;
        id_d[CREG_W'(r)]    = issue_id;
      end else if (commit_valid && commit_dst == CREG_W'(r) && busy_q[CREG_W'(r)]
                   && commit_id == id_q[CREG_W'(r)]) begin
        busy_d[CREG_W'(r)]  = 1'b0;
        ready_d[CREG_W'(r)] = 1'b0;
        id_d[CREG_W'(r)]    = '0;
        data_d[CREG_W'(r)]  = '0;
      end else if (done_valid && done_dst == CREG_W'(r) && busy_q[CREG_W'(r)]
                   && done_id == id_q[CREG_W'(r)]) begin
        ready_d[CREG_W'(r)] = 1'b1;
        data_d[CREG_W'(r)]  = done_data;
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned r = 0; r < NUM_CREGS; r++) begin
      busy_cnt_d = busy_cnt_d + SB_CNT_W'(busy_d[CREG_W'(r)]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      ready_q  <= '0;
      id_q     <= '{default: '0};
      data_q   <= '{default: '0};
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      id_q     <= id_d;
      data_q   <= data_d;
      busy_cnt <= busy_cnt_d;
    end
  end

  sb_query #(.ID_W(ID_W)) u_query1 (
    .busy       (busy_q),
    .ready      (ready_q),
    .id         (id_q),
    .data       (data_q),
    .done_valid (done_valid),
    .done_dst   (done_dst),
    .done_id    (done_id),
    .done_data  (done_data),
    .src        (src1),
    .fwd_c      (fwd1),
    .pending_c  (pending1_c)
  );

  sb_query #(.ID_W(ID_W)) u_query2 (
    .busy       (busy_q),
    .ready      (ready_q),
    .id         (id_q),
    .data       (data_q),
    .done_valid (done_valid),
    .done_dst   (done_dst),
    .done_id    (done_id),
    .done_data  (done_data),
    .src        (src2),
    .fwd_c      (fwd2),
    .pending_c  (pending2_c)
  );

  assign stall = pending1_c | pending2_c;

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Producer-side forwarding source for the pipeline. Tracks long-latency writes (load, mul/div) from issue until regfile commit, holds completed results for forwarding, and answers two decode-stage source queries with a `fwd_data_t` result and a stall request. Existing per-stage forwarding comparators remain the consumers of stage-resident results. This block serves results that have left the execute pipe but are not yet architecturally written.

## Interface
- `ID_W`, 3: width of the producer tag distinguishing successive writes to one register.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: discard all tracked writes.
- `issue_valid` in 1, `issue_dst` in `creg_addr_t`, `issue_id` in `ID_W`: a long-latency op claims `issue_dst`.
- `done_valid` in 1, `done_dst` in `creg_addr_t`, `done_id` in `ID_W`, `done_data` in `word_t`: result available.
- `commit_valid` in 1, `commit_dst` in `creg_addr_t`, `commit_id` in `ID_W`: result written to regfile.
- `src1`, `src2` in `creg_addr_t`: decode-stage source registers.
- `fwd1`, `fwd2` out `fwd_data_t`: forwarded value; `enable` is 1 when valid.
- `stall` out 1: a source is pending with no data.
- `busy_cnt` out 6: number of tracked entries.

## Operation
- 32 entries indexed by register. Each entry holds `busy`, `ready`, `id`, and `data`. Entry 0 is never set; `issue_dst==0` is ignored.
- Per-entry next state, highest priority first:
  1. `reset` or `flush`: entry cleared.
  2. Issue hit: `busy=1`, `ready=0`, `id=issue_id`, `data` unchanged. This covers WAW: the new issue overwrites the older claim.
  3. Commit hit with matching `id`: entry cleared.
  4. Done hit with matching `id`: `ready=1`, `data=done_data`.
- A done or commit with a non-matching id is stale and ignored.
- Query for source `s` (`s≠0`, entry busy):
  - If `ready`: `fwd.enable=1`, `fwd.data=data`.
  - Else if `done_valid`, `done_dst==s`, and `done_id` matches: same-cycle bypass, `enable=1`, `data=done_data`.
  - Else `enable=0` and the source contributes to stall.
- `s==0` or entry not busy: `fwd='0`, no stall.
- `stall` = pending(src1) OR pending(src2).
- The issue port is not visible to queries in the same cycle. Stage forwarding covers that case.
- `busy_cnt` = popcount of `busy`. It is registered and reflects the post-update state.

## Timing
- Reset and flush take effect at the next edge. After that edge all entries are clear, `fwd1`/`fwd2`='0, `stall`=0, `busy_cnt`=0.
- Flush asserted together with issue: the issue is dropped.
- Issue at cycle N: the entry is busy from N+1; `busy_cnt` increments at N+1.
- Done at cycle M: forwarded combinationally at M via bypass, and from the register at M+1 onward.
- Commit at cycle K: the entry clears at K+1. Commit and done in the same cycle with matching id: commit wins (cleared).
- Issue and commit to the same dst in the same cycle: issue wins, and the entry holds the new id.
- Outputs `fwd*` and `stall` are combinational from the entry state and the done port. No cycle of latency is added for queries.
- Up to one issue, one done, and one commit per cycle, to any mix of registers.

## Structure
- Add `sb_entry_t` (`busy`, `ready`, `id`, `data`) to `pipes`. `ID_W` defaults in `common` as `SB_ID_W`.
- Reuse `fwd_data_t`, `creg_addr_t`, and `word_t` from existing packages.
- Sub-module `sb_query`: one instance per source. Combinational lookup plus bypass, producing `fwd_data_t` and a pending flag.
- Entry update logic stays in the top level.

## Test plan
- Reset, then query `src1=5`: `fwd1.enable=0`, `stall=0`, `busy_cnt=0`.
- Issue x5 id=2 at N; query `src1=5` at N+1: `stall=1`. Done x5 id=2 with data `0xDEAD` at N+3: `fwd1={1,0xDEAD}` and `stall=0` at N+3 (bypass) and N+4. Commit id=2 at N+5: from N+6 `fwd1.enable=0`, `busy_cnt=0`.
- WAW case:
  - Issue x7 id=1, then issue x7 id=4.
  - Done x7 id=1 with data 0x11: ignored, `stall` stays 1.
  - Done id=4 with data 0x44: `fwd=0x44`.
  - Commit id=1: ignored, entry stays.
- Issue x0: nothing tracked. Query `src2=0` always gives `fwd2='0`, `stall=0`.
- Issue x3, x9, x12: `busy_cnt=3`. Flush the same cycle as an issue of x15: next cycle `busy_cnt=0` and x15 is not tracked.
- Same-cycle events:
  - Done and commit for x3 id=0 together: cleared next cycle.
  - Issue x3 id=5 together with commit x3 id=0: entry busy with id=5, `ready=0`.
